// File: rtl/sensor_pkg.sv
// Shared definitions for the parking-lot sensor front end: channel state
// encoding, default debounce timing and the occupancy FSM's {a,b} codes.
package sensor_pkg;

    typedef enum logic [1:0] {
        ST_ZERO  = 2'd0,
        ST_WAIT1 = 2'd1,
        ST_ONE   = 2'd2,
        ST_WAIT0 = 2'd3
    } ch_state_t;

    // 10 ms of stable input at 100 MHz
    localparam int DEF_STABLE_CYCLES = 1000000;
    localparam int DEF_CNT_W         = 20;

    // {a,b} codes seen by the occupancy FSM
    localparam logic [1:0] AB_CLEAR = 2'b00;
    localparam logic [1:0] AB_OUTER = 2'b10;
    localparam logic [1:0] AB_BOTH  = 2'b11;
    localparam logic [1:0] AB_INNER = 2'b01;

endpackage

// File: rtl/db_channel.sv
// One sensor channel: 2-flop synchroniser, 4-state debounce FSM with a
// down-counter, and registered level / edge / reject pulses.
module db_channel
    import sensor_pkg::*;
#(
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise,
    output logic o_fall,
    output logic o_glitch
);

    localparam logic [CNT_W-1:0] LP_LOAD = CNT_W'(STABLE_CYCLES - 1);

    logic             r_s1;
    logic             r_s2;
    ch_state_t        r_state;
    ch_state_t        w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_out;
    logic             w_out_nxt;
    logic             r_rise;
    logic             w_rise_nxt;
    logic             r_fall;
    logic             w_fall_nxt;
    logic             r_glitch;
    logic             w_glitch_nxt;

    // Synchroniser for the asynchronous raw sensor line
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= i_raw;
            r_s2 <= r_s1;
        end
    end

    // State, counter and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_ZERO;
            r_cnt    <= {CNT_W{1'b0}};
            r_out    <= 1'b0;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
            r_glitch <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_out    <= w_out_nxt;
            r_rise   <= w_rise_nxt;
            r_fall   <= w_fall_nxt;
            r_glitch <= w_glitch_nxt;
        end
    end

    // Next-state logic; the counter only moves while a change is pending
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_rise_nxt   = 1'b0;
        w_fall_nxt   = 1'b0;
        w_glitch_nxt = 1'b0;
        case (r_state)
            ST_ZERO: begin
                if (r_s2) begin
                    w_state_nxt = ST_WAIT1;
                    w_cnt_nxt   = LP_LOAD;
                end else begin
                    w_state_nxt = ST_ZERO;
                end
            end
            ST_WAIT1: begin
                if (!r_s2) begin
                    w_state_nxt  = ST_ZERO;
                    w_glitch_nxt = 1'b1;
                end else if (r_cnt == {CNT_W{1'b0}}) begin
                    w_state_nxt = ST_ONE;
                    w_rise_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            ST_ONE: begin
                if (!r_s2) begin
                    w_state_nxt = ST_WAIT0;
                    w_cnt_nxt   = LP_LOAD;
                end else begin
                    w_state_nxt = ST_ONE;
                end
            end
            ST_WAIT0: begin
                if (r_s2) begin
                    w_state_nxt  = ST_ONE;
                    w_glitch_nxt = 1'b1;
                end else if (r_cnt == {CNT_W{1'b0}}) begin
                    w_state_nxt = ST_ZERO;
                    w_fall_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_ZERO;
                w_cnt_nxt   = {CNT_W{1'b0}};
            end
        endcase
        // Level follows the state it lands in, so it can never disagree with it
        w_out_nxt = (w_state_nxt == ST_ONE) || (w_state_nxt == ST_WAIT0);
    end

    assign o_level  = r_out;
    assign o_rise   = r_rise;
    assign o_fall   = r_fall;
    assign o_glitch = r_glitch;

endmodule

// File: rtl/sensor_debounce.sv
// Two independent debounced sensor channels (outer a, inner b) feeding the
// occupancy FSM, with a shared glitch-reject pulse.
module sensor_debounce
    import sensor_pkg::*;
#(
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic a_raw,
    input  logic b_raw,
    output logic a,
    output logic b,
    output logic a_rise,
    output logic a_fall,
    output logic b_rise,
    output logic b_fall,
    output logic glitch
);

    logic w_glitch_a;
    logic w_glitch_b;

    db_channel #(
        .STABLE_CYCLES (STABLE_CYCLES),
        .CNT_W         (CNT_W)
    ) u_ch_a (
        .clk      (clk),
        .reset    (reset),
        .i_raw    (a_raw),
        .o_level  (a),
        .o_rise   (a_rise),
        .o_fall   (a_fall),
        .o_glitch (w_glitch_a)
    );

    db_channel #(
        .STABLE_CYCLES (STABLE_CYCLES),
        .CNT_W         (CNT_W)
    ) u_ch_b (
        .clk      (clk),
        .reset    (reset),
        .i_raw    (b_raw),
        .o_level  (b),
        .o_rise   (b_rise),
        .o_fall   (b_fall),
        .o_glitch (w_glitch_b)
    );

    // Both sources are registered pulses, so the OR stays single-cycle
    assign glitch = w_glitch_a | w_glitch_b;

endmodule
